// File: rtl/rat_flags.sv
// RAT MCU status flags (C, Z), shadow C/Z, interrupt enable and pending-interrupt latch.
// Define FLAGS_SYNC_EN to put a SYNC_STAGES-deep synchronizer on INTR ahead of the edge detector.
module rat_flags #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic C_IN,
    input  logic Z_IN,
    input  logic FLG_C_LD,
    input  logic FLG_C_SET,
    input  logic FLG_C_CLR,
    input  logic FLG_Z_LD,
    input  logic FLG_LD_SEL,
    input  logic FLG_SHAD_LD,
    input  logic I_SET,
    input  logic I_CLR,
    input  logic INTR,
    input  logic INT_ACK,
    output logic C_FLAG,
    output logic Z_FLAG,
    output logic SHAD_C,
    output logic SHAD_Z,
    output logic I_FLAG,
    output logic INT_PEND,
    output logic INT_REQ
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("rat_flags: SYNC_STAGES must be in 2..4");
    end

    logic r_c, r_z, r_shad_c, r_shad_z, r_i, r_pend, r_intr_prev;
    logic w_c_nxt, w_z_nxt, w_shad_c_nxt, w_shad_z_nxt, w_i_nxt, w_pend_nxt;
    logic w_c_src, w_z_src, w_intr, w_edge;

`ifdef FLAGS_SYNC_EN
    logic [SYNC_STAGES-1:0] r_sync;

    // INTR synchronizer chain
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], INTR};
        end
    end

    assign w_intr = r_sync[SYNC_STAGES-1];
`else
    assign w_intr = INTR;
`endif

    assign w_edge = w_intr & ~r_intr_prev;

    // Next-state logic for flags, shadow, interrupt enable and pending latch
    always_comb begin
        w_c_src      = FLG_LD_SEL ? r_shad_c : C_IN;
        w_z_src      = FLG_LD_SEL ? r_shad_z : Z_IN;
        w_c_nxt      = r_c;
        w_z_nxt      = r_z;
        w_shad_c_nxt = r_shad_c;
        w_shad_z_nxt = r_shad_z;
        w_i_nxt      = r_i;
        w_pend_nxt   = r_pend;

        if (FLG_C_CLR) begin
            w_c_nxt = 1'b0;
        end else if (FLG_C_SET) begin
            w_c_nxt = 1'b1;
        end else if (FLG_C_LD) begin
            w_c_nxt = w_c_src;
        end else begin
            w_c_nxt = r_c;
        end

        if (FLG_Z_LD) begin
            w_z_nxt = w_z_src;
        end else begin
            w_z_nxt = r_z;
        end

        // Shadow captures pre-edge flags, so a same-cycle restore swaps
        if (FLG_SHAD_LD || INT_ACK) begin
            w_shad_c_nxt = r_c;
            w_shad_z_nxt = r_z;
        end else begin
            w_shad_c_nxt = r_shad_c;
            w_shad_z_nxt = r_shad_z;
        end

        if (I_CLR || INT_ACK) begin
            w_i_nxt = 1'b0;
        end else if (I_SET) begin
            w_i_nxt = 1'b1;
        end else begin
            w_i_nxt = r_i;
        end

        // A new edge wins over acknowledge so the fresh request is kept
        if (w_edge) begin
            w_pend_nxt = 1'b1;
        end else if (INT_ACK) begin
            w_pend_nxt = 1'b0;
        end else begin
            w_pend_nxt = r_pend;
        end
    end

    // State registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_shad_c    <= 1'b0;
            r_shad_z    <= 1'b0;
            r_i         <= 1'b0;
            r_pend      <= 1'b0;
            r_intr_prev <= 1'b0;
        end else begin
            r_c         <= w_c_nxt;
            r_z         <= w_z_nxt;
            r_shad_c    <= w_shad_c_nxt;
            r_shad_z    <= w_shad_z_nxt;
            r_i         <= w_i_nxt;
            r_pend      <= w_pend_nxt;
            r_intr_prev <= w_intr;
        end
    end

    assign C_FLAG   = r_c;
    assign Z_FLAG   = r_z;
    assign SHAD_C   = r_shad_c;
    assign SHAD_Z   = r_shad_z;
    assign I_FLAG   = r_i;
    assign INT_PEND = r_pend;
    assign INT_REQ  = r_pend & r_i;

endmodule
